// File: rtl/sb_config_loader.sv
// sb_config_loader: assembles byte-stream segments into switch-box config frames
// and strobes each frame into its tile, stepping through every tile in order.
module sb_config_loader #(
  parameter int CONFIG_WIDTH = 112,
  parameter int WORD_WIDTH = 8,
  parameter int TILE_COUNT = 12,
  localparam int TW = (TILE_COUNT > 1) ? $clog2(TILE_COUNT) : 1
) (
  input  logic                    clock,
  input  logic                    nreset,
  input  logic                    start,
  input  logic                    abort,
  input  logic [WORD_WIDTH-1:0]   word_in,
  input  logic                    word_valid,
  output logic                    word_ready,
  output logic [CONFIG_WIDTH-1:0] config_out,
  output logic [TW-1:0]           config_tile,
  output logic                    config_we,
  output logic                    busy,
  output logic                    done
);
  localparam int FRAME_WORDS = (CONFIG_WIDTH + WORD_WIDTH - 1) / WORD_WIDTH;
  localparam int WC = $clog2(FRAME_WORDS + 1);
  localparam logic [WC-1:0] LAST_W = WC'(FRAME_WORDS - 1);
  localparam logic [TW-1:0] LAST_T = TW'(TILE_COUNT - 1);
  typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;
  state_t                  state_q;
  logic [WC-1:0]           word_cnt_q;
  logic [TW-1:0]           tile_cnt_q;
  logic [CONFIG_WIDTH-1:0] cfg_q, cfg_d;
  logic                    we_q, busy_q, done_q;
  logic                    xfer;
  // abort wins over a simultaneous word, so the word is refused rather than dropped
  assign word_ready = (state_q == LOAD) && !abort;
  assign xfer = word_ready && word_valid;
  always_comb begin
    cfg_d = cfg_q;
    for (int k = 0; k < FRAME_WORDS; k++)
      for (int b = 0; b < WORD_WIDTH; b++)
        if (xfer && word_cnt_q == WC'(k) && k * WORD_WIDTH + b < CONFIG_WIDTH)
          cfg_d[k * WORD_WIDTH + b] = word_in[b];
  end
  always_ff @(posedge clock) begin
    if (!nreset) begin
      state_q    <= IDLE;
      word_cnt_q <= '0;
      tile_cnt_q <= '0;
      cfg_q      <= '0;
      we_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      cfg_q <= cfg_d;
      we_q  <= 1'b0;
      case (state_q)
        IDLE, DONE: if (start) begin
          state_q    <= LOAD;
          word_cnt_q <= '0;
          tile_cnt_q <= '0;
          busy_q     <= 1'b1;
          done_q     <= 1'b0;
        end
        LOAD: if (abort) begin
          state_q    <= IDLE;
          word_cnt_q <= '0;
          tile_cnt_q <= '0;
          busy_q     <= 1'b0;
        end else if (word_valid) begin
          word_cnt_q <= word_cnt_q + WC'(1);
          if (word_cnt_q == LAST_W) begin
            state_q <= WRITE;
            we_q    <= 1'b1;
          end
        end
        WRITE: if (abort) begin
          state_q    <= IDLE;
          word_cnt_q <= '0;
          tile_cnt_q <= '0;
          busy_q     <= 1'b0;
        end else if (tile_cnt_q == LAST_T) begin
          state_q <= DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end else begin
          state_q    <= LOAD;
          tile_cnt_q <= tile_cnt_q + TW'(1);
          word_cnt_q <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign config_out  = cfg_q;
  assign config_tile = tile_cnt_q;
  assign config_we   = we_q;
  assign busy        = busy_q;
  assign done        = done_q;
endmodule

// File: tb/tb_sb_config_loader.sv
// tb_sb_config_loader: random-stimulus bench with a word-count based reference model
module tb_sb_config_loader;
  localparam int CW = 112, W = 8, TC = 12, FW = 14;
  logic clock = 0, nreset = 0, start = 0, abort = 0, word_valid = 0;
  logic rnd = 1, clr = 0;
  logic [W-1:0] rw = '0, word_in;
  logic word_ready, config_we, busy, done;
  logic [CW-1:0] config_out;
  logic [3:0] config_tile;
  int tests = 0, fails = 0, cyc = 0, sent = 0, start_cyc = 0;
  int gold_t = 0, we_cnt = 0, last_we = -1;
  bit spacing = 0;
  bit m_busy = 0, m_wr = 0, m_done = 0;
  int m_acc = 0, m_hold = 0;
  logic [CW-1:0] m_cfg = '0;

  sb_config_loader dut (
    .clock(clock), .nreset(nreset), .start(start), .abort(abort),
    .word_in(word_in), .word_valid(word_valid), .word_ready(word_ready),
    .config_out(config_out), .config_tile(config_tile), .config_we(config_we),
    .busy(busy), .done(done)
  );

  always #5 clock = ~clock;
  assign word_in = rnd ? rw : sent[7:0];
  always @(posedge clock) begin
    cyc  <= cyc + 1;
    sent <= clr ? 0 : sent + ((nreset && word_valid && word_ready) ? 1 : 0);
  end

  task automatic chk(input string nm, input int a, input int e);
    tests++;
    if (a != e) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, a, e, cyc);
    end
  endtask

  task automatic chk_cfg(input string nm, input logic [CW-1:0] a, input logic [CW-1:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, a, e, cyc);
    end
  endtask

  // Reference: progress is the number of words accepted since start; every FW words
  // earns one write cycle, and TC frames end the load.
  initial forever begin
    @(posedge clock);
    if (!nreset) begin
      m_busy = 0; m_wr = 0; m_done = 0; m_acc = 0; m_hold = 0; m_cfg = '0;
    end else if (m_busy) begin
      if (abort) begin
        m_busy = 0; m_wr = 0; m_acc = 0; m_hold = 0;
      end else if (m_wr) begin
        m_wr = 0;
        if (m_acc == TC * FW) begin
          m_busy = 0; m_done = 1; m_hold = TC - 1;
        end
      end else if (word_valid) begin
        for (int b = 0; b < W; b++)
          if ((m_acc % FW) * W + b < CW) m_cfg[(m_acc % FW) * W + b] = word_in[b];
        m_acc++;
        if (m_acc % FW == 0) m_wr = 1;
      end
    end else if (start) begin
      m_busy = 1; m_done = 0; m_acc = 0; m_hold = 0;
    end
  end

  initial forever begin
    @(negedge clock);
    if (cyc > 0) begin
      chk("word_ready", int'(word_ready), int'(m_busy && !m_wr && !abort));
      chk("busy", int'(busy), int'(m_busy));
      chk("done", int'(done), int'(m_done));
      chk("config_we", int'(config_we), int'(m_wr));
      chk("config_tile", int'(config_tile), m_busy ? (m_wr ? m_acc / FW - 1 : m_acc / FW) : m_hold);
      chk_cfg("config_out", config_out, m_cfg);
      if (clr) begin
        gold_t = 0; we_cnt = 0; last_we = -1;
      end
      if (config_we === 1'b1) begin
        chk("we_tile", int'(config_tile), gold_t);
        for (int k = 0; k < FW; k++)
          chk("frame_byte", int'(config_out[k*W +: W]), (FW * gold_t + k) % 256);
        if (spacing && last_we >= 0) chk("we_spacing", cyc - last_we, FW + 1);
        last_we = cyc;
        gold_t++;
        we_cnt++;
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_start();
    start = 1; clr = 1;
    step();
    start = 0; clr = 0;
    start_cyc = cyc;
  endtask

  task automatic run(input int stall, input bit noise);
    int n = 0;
    while (done !== 1'b1 && n < 3000) begin
      word_valid = ($urandom_range(99) >= stall);
      start = noise && busy && ($urandom_range(7) == 0);
      step();
      n++;
    end
    start = 0; word_valid = 0;
    chk("run_reaches_done", int'(done === 1'b1), 1);
  endtask

  task automatic reset_outputs(input string nm);
    chk({nm, "_ready"}, int'(word_ready), 0);
    chk({nm, "_we"}, int'(config_we), 0);
    chk({nm, "_busy"}, int'(busy), 0);
    chk({nm, "_done"}, int'(done), 0);
    chk({nm, "_tile"}, int'(config_tile), 0);
    chk_cfg({nm, "_cfg"}, config_out, '0);
  endtask

  initial begin
    int n;
    repeat (2) begin
      start = 1'($urandom); abort = 1'($urandom); word_valid = 1'($urandom); rw = 8'($urandom);
      step();
    end
    reset_outputs("reset");
    nreset = 1; rnd = 0; start = 0; abort = 0; word_valid = 0;
    step();
    // full load, stream never stalls
    spacing = 1;
    do_start();
    run(0, 0);
    chk("done_cycle", cyc - start_cyc + 1, 181);
    chk("we_count_full", we_cnt, TC);
    spacing = 0;
    repeat (3) step();
    // restart from DONE with a stalled stream and ignored start pulses
    do_start();
    chk("done_drops_on_restart", int'(done), 0);
    chk("busy_on_restart", int'(busy), 1);
    run(50, 1);
    chk("we_count_stalled", we_cnt, TC);
    // abort during tile 3, after its 7th word, alongside a valid word
    do_start();
    n = 0;
    while (sent < 3 * FW + 7 && n < 500) begin
      word_valid = ($urandom_range(99) >= 30);
      step();
      n++;
    end
    chk("abort_words_reached", sent, 3 * FW + 7);
    word_valid = 1; abort = 1;
    #1;
    chk("abort_ready_low", int'(word_ready), 0);
    step();
    abort = 0; word_valid = 0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_word_not_taken", sent, 3 * FW + 7);
    chk("abort_we_count", we_cnt, 3);
    abort = 1;
    step();
    abort = 0;
    do_start();
    run(30, 0);
    chk("we_count_after_abort", we_cnt, TC);
    // reset in the write cycle of tile 5
    do_start();
    n = 0;
    while (!(config_we === 1'b1 && config_tile == 4'd5) && n < 500) begin
      word_valid = 1;
      step();
      n++;
    end
    chk("reached_tile5_write", int'(config_we === 1'b1 && config_tile == 4'd5), 1);
    nreset = 0;
    step();
    nreset = 1; word_valid = 0;
    reset_outputs("midwrite_reset");
    step();
    spacing = 1;
    do_start();
    run(0, 0);
    chk("we_count_after_reset", we_cnt, TC);
    chk("done_cycle_after_reset", cyc - start_cyc + 1, 181);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
